// File: rtl/alu_cmd_sequencer_if.sv
// Command and response streams of the ALU command sequencer, both valid/ready.
// master = instruction source / result consumer side, slave = sequencer side.
interface alu_cmd_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_ctl;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [2:0] rsp_ctl;
    logic [3:0] rsp_result;
    logic [4:0] rsp_flags;

    modport master (
        output cmd_valid, cmd_ctl, cmd_a, cmd_b,
        input  cmd_ready,
        input  rsp_valid, rsp_ctl, rsp_result, rsp_flags,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_ctl, cmd_a, cmd_b,
        output cmd_ready,
        output rsp_valid, rsp_ctl, rsp_result, rsp_flags,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Purpose: queue ALU commands, drive an external 4-bit ALU, return sampled results.
// Latency: command to alu_* 1 cycle, to rsp_valid 2 cycles; one op per 2 cycles sustained.
// Backpressure: cmd_ready drops when the FIFO is full; rsp_* hold while rsp_ready is low.
// Optional ALU_LOCAL_ZERO_EN: derive the zero flag from alu_result instead of alu_zero.
module alu_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_cmd_sequencer_if.slave bus,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [2:0]       alu_ctl,
    input  logic [3:0]       alu_result,
    input  logic             alu_overflow,
    input  logic             alu_carry,
    input  logic             alu_zero,
    input  logic             alu_out0,
    input  logic             alu_out1,
    output logic             busy,
    output logic [CNT_W-1:0] op_cnt
);

    typedef struct packed {
        logic [2:0] ctl;
        logic [3:0] a;
        logic [3:0] b;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t     state, state_nxt;
    cmd_t       push_dat;
    cmd_t       head;
    logic       head_vld;
    logic       pop;
    logic       load;
    logic       capture;
    logic       rsp_done;
    logic       zero_flag;

    logic       rsp_valid_q;
    logic [2:0] rsp_ctl_q;
    logic [3:0] rsp_result_q;
    logic [4:0] rsp_flags_q;

    assign push_dat = {bus.cmd_ctl, bus.cmd_a, bus.cmd_b};

    alu_cmd_sequencer_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (bus.cmd_valid),
        .push_rdy (bus.cmd_ready),
        .push_dat (push_dat),
        .pop_vld  (head_vld),
        .pop_rdy  (pop),
        .pop_dat  (head)
    );

`ifdef ALU_LOCAL_ZERO_EN
    // slt/eq opcodes put a boolean in result, so a zero there is not meaningful
    assign zero_flag = (alu_ctl[2:1] != 2'b11) && (alu_result == 4'b0000);
    logic unused_alu_zero;
    assign unused_alu_zero = alu_zero;
`else
    assign zero_flag = alu_zero;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load      = 1'b0;
        capture   = 1'b0;
        rsp_done  = 1'b0;
        case (state)
            IDLE: begin
                if (head_vld) begin
                    pop       = 1'b1;
                    load      = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                capture   = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_done = 1'b1;
                    // back-to-back issue keeps throughput at one op per 2 cycles
                    if (head_vld) begin
                        pop       = 1'b1;
                        load      = 1'b1;
                        state_nxt = ISSUE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a        <= '0;
            alu_b        <= '0;
            alu_ctl      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_ctl_q    <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            op_cnt       <= '0;
        end else begin
            if (load) begin
                alu_a   <= head.a;
                alu_b   <= head.b;
                alu_ctl <= head.ctl;
            end
            if (capture) begin
                rsp_valid_q  <= 1'b1;
                rsp_ctl_q    <= alu_ctl;
                rsp_result_q <= alu_result;
                rsp_flags_q  <= {alu_out1, alu_out0, zero_flag, alu_carry, alu_overflow};
            end else if (rsp_done) begin
                rsp_valid_q  <= 1'b0;
            end
            if (rsp_done) begin
                op_cnt <= op_cnt + 1'b1;
            end
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_ctl    = rsp_ctl_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_flags  = rsp_flags_q;

    assign busy = (state != IDLE) || head_vld;

endmodule

// Generic synchronous FIFO, count-based full/empty, pointers wrap modulo DEPTH.
// Zero-latency read of the head; push_rdy is simply !full.
module alu_cmd_sequencer_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    output logic             push_rdy,
    input  logic [WIDTH-1:0] push_dat,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push;
    logic             pop;

    assign push_rdy = (count != FULL_CNT);
    assign pop_vld  = (count != '0);
    assign push     = push_vld && push_rdy;
    assign pop      = pop_rdy && pop_vld;
    assign pop_dat  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench: two sequencers (CNT_W=8 and CNT_W=2) share one command stream,
// each driving a behavioural stand-in for the team ALU.
module tb_alu_cmd_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_cmd_sequencer_if bus ();
    alu_cmd_sequencer_if bus2 ();

    logic [3:0] alu_a, alu_b, alu_a2, alu_b2;
    logic [2:0] alu_ctl, alu_ctl2;
    logic [8:0] alu_o, alu_o2;
    logic       busy, busy2;
    logic [7:0] op_cnt;
    logic [1:0] op_cnt2;

    // returns {result[3:0], out1, out0, zero, carry, overflow}; carry is carry into the MSB
    function automatic logic [8:0] alu_f(input logic [2:0] ctl, input logic [3:0] a, input logic [3:0] b);
        logic [3:0] bb, r, lo;
        logic [4:0] full;
        logic       cin, arith, o0, o1, ovf, cy, z;
        arith = (ctl == 3'b000) || (ctl == 3'b001);
        cin   = (ctl == 3'b001);
        bb    = cin ? ~b : b;
        lo    = {1'b0, a[2:0]} + {1'b0, bb[2:0]} + {3'b000, cin};
        full  = {1'b0, a} + {1'b0, bb} + {4'b0000, cin};
        o0    = $signed(a) < $signed(b);
        o1    = (a == b);
        case (ctl)
            3'b000, 3'b001: r = full[3:0];
            3'b010:         r = a | b;
            3'b011:         r = a & b;
            3'b100:         r = a ^ b;
            3'b101:         r = ~(a | b);
            3'b110:         r = {3'b000, o0};
            default:        r = {3'b000, o1};
        endcase
        ovf = arith & (lo[3] ^ full[4]);
        cy  = arith & lo[3];
        z   = (ctl == 3'b001) && (r == 4'b0000);
        return {r, o1, o0, z, cy, ovf};
    endfunction

    assign alu_o  = alu_f(alu_ctl, alu_a, alu_b);
    assign alu_o2 = alu_f(alu_ctl2, alu_a2, alu_b2);

    assign bus2.cmd_valid = bus.cmd_valid;
    assign bus2.cmd_ctl   = bus.cmd_ctl;
    assign bus2.cmd_a     = bus.cmd_a;
    assign bus2.cmd_b     = bus.cmd_b;
    assign bus2.rsp_ready = bus.rsp_ready;

    alu_cmd_sequencer #(.DEPTH(4), .CNT_W(8)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_ctl      (alu_ctl),
        .alu_result   (alu_o[8:5]),
        .alu_overflow (alu_o[0]),
        .alu_carry    (alu_o[1]),
        .alu_zero     (alu_o[2]),
        .alu_out0     (alu_o[3]),
        .alu_out1     (alu_o[4]),
        .busy         (busy),
        .op_cnt       (op_cnt)
    );

    alu_cmd_sequencer #(.DEPTH(4), .CNT_W(2)) u_dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus2),
        .alu_a        (alu_a2),
        .alu_b        (alu_b2),
        .alu_ctl      (alu_ctl2),
        .alu_result   (alu_o2[8:5]),
        .alu_overflow (alu_o2[0]),
        .alu_carry    (alu_o2[1]),
        .alu_zero     (alu_o2[2]),
        .alu_out0     (alu_o2[3]),
        .alu_out1     (alu_o2[4]),
        .busy         (busy2),
        .op_cnt       (op_cnt2)
    );

    int checks = 0;
    int errors = 0;

    logic [2:0] t_ctl [6];
    logic [3:0] t_a   [6];
    logic [3:0] t_b   [6];
    logic [3:0] t_res [6];
    logic [4:0] t_flg [6];
    int         cnt2_exp [6];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [2:0] c, input logic [3:0] a, input logic [3:0] b);
        bus.cmd_ctl   = c;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_valid = 1'b1;
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.rsp_valid) begin
                ok = 1'b1;
                break;
            end
            tick;
        end
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_cmd_ready"}, 32'(bus.cmd_ready), 32'h1);
        check({pfx, "_alu_a"}, 32'(alu_a), 32'h0);
        check({pfx, "_alu_b"}, 32'(alu_b), 32'h0);
        check({pfx, "_alu_ctl"}, 32'(alu_ctl), 32'h0);
        check({pfx, "_rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
        check({pfx, "_rsp_ctl"}, 32'(bus.rsp_ctl), 32'h0);
        check({pfx, "_rsp_result"}, 32'(bus.rsp_result), 32'h0);
        check({pfx, "_rsp_flags"}, 32'(bus.rsp_flags), 32'h0);
        check({pfx, "_busy"}, 32'(busy), 32'h0);
        check({pfx, "_op_cnt"}, 32'(op_cnt), 32'h0);
        check({pfx, "_op_cnt2"}, 32'(op_cnt2), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   ok;
        bit   hs, acc_now, rdy;
        int   acc, nrsp, last;
        logic [2:0] o_ctl;
        logic [3:0] o_res;
        logic [4:0] o_flg;

        t_ctl[0] = 3'b001; t_a[0] = 4'h3; t_b[0] = 4'h5; t_res[0] = 4'hE; t_flg[0] = 5'b01000;
        t_ctl[1] = 3'b001; t_a[1] = 4'h6; t_b[1] = 4'h6; t_res[1] = 4'h0; t_flg[1] = 5'b10110;
        t_ctl[2] = 3'b010; t_a[2] = 4'h5; t_b[2] = 4'hA; t_res[2] = 4'hF; t_flg[2] = 5'b00000;
        t_ctl[3] = 3'b100; t_a[3] = 4'h9; t_b[3] = 4'h3; t_res[3] = 4'hA; t_flg[3] = 5'b01000;
        t_ctl[4] = 3'b110; t_a[4] = 4'h7; t_b[4] = 4'h2; t_res[4] = 4'h0; t_flg[4] = 5'b00000;
        t_ctl[5] = 3'b111; t_a[5] = 4'h4; t_b[5] = 4'h4; t_res[5] = 4'h1; t_flg[5] = 5'b10000;
        cnt2_exp[0] = 1; cnt2_exp[1] = 2; cnt2_exp[2] = 3;
        cnt2_exp[3] = 0; cnt2_exp[4] = 1; cnt2_exp[5] = 2;

        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_ctl   = 3'b000;
        bus.cmd_a     = 4'h0;
        bus.cmd_b     = 4'h0;
        bus.rsp_ready = 1'b0;
        tick;
        tick;
        check_reset("rst");
        @(negedge clk) rst_n = 1'b1;
        tick;

        // single add 7+1: latency and flags
        bus.rsp_ready = 1'b1;
        drive_cmd(3'b000, 4'h7, 4'h1);
        check("t1_cmd_ready", 32'(bus.cmd_ready), 32'h1);
        tick;
        bus.cmd_valid = 1'b0;
        check("t1_rsp_n0", 32'(bus.rsp_valid), 32'h0);
        check("t1_busy", 32'(busy), 32'h1);
        tick;
        check("t1_alu_a", 32'(alu_a), 32'h7);
        check("t1_alu_b", 32'(alu_b), 32'h1);
        check("t1_alu_ctl", 32'(alu_ctl), 32'h0);
        check("t1_rsp_n1", 32'(bus.rsp_valid), 32'h0);
        tick;
        check("t1_rsp_n2", 32'(bus.rsp_valid), 32'h1);
        check("t1_result", 32'(bus.rsp_result), 32'h8);
        check("t1_flags", 32'(bus.rsp_flags), 32'h03);
        check("t1_ctl", 32'(bus.rsp_ctl), 32'h0);
        tick;
        check("t1_rsp_drop", 32'(bus.rsp_valid), 32'h0);
        check("t1_op_cnt", 32'(op_cnt), 32'h1);
        check("t1_op_cnt2", 32'(op_cnt2), 32'h1);
        check("t1_busy_idle", 32'(busy), 32'h0);

        // and C&3: zero flag source depends on the build
        drive_cmd(3'b011, 4'hC, 4'h3);
        tick;
        bus.cmd_valid = 1'b0;
        wait_rsp(ok);
        check("t2_rsp_seen", 32'(ok), 32'h1);
        check("t2_result", 32'(bus.rsp_result), 32'h0);
`ifdef ALU_LOCAL_ZERO_EN
        check("t2_flags", 32'(bus.rsp_flags), 32'h0C);
`else
        check("t2_flags", 32'(bus.rsp_flags), 32'h08);
`endif
        tick;
        check("t2_op_cnt", 32'(op_cnt), 32'h2);

        // backpressure fill then drain of six commands
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        tick;
        check("t3_op_cnt_rst", 32'(op_cnt), 32'h0);
        bus.rsp_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            drive_cmd(t_ctl[acc], t_a[acc], t_b[acc]);
            rdy = bus.cmd_ready;
            tick;
            if (rdy) acc++;
        end
        check("t3_accepted", 32'(acc), 32'h5);
        check("t3_cmd_ready_full", 32'(bus.cmd_ready), 32'h0);
        check("t3_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        check("t3_hold_result", 32'(bus.rsp_result), 32'hE);
        check("t3_hold_flags", 32'(bus.rsp_flags), 32'h08);
        check("t3_hold_ctl", 32'(bus.rsp_ctl), 32'h1);
        check("t3_hold_op_cnt", 32'(op_cnt), 32'h0);
        tick;
        tick;
        tick;
        check("t3_frozen_valid", 32'(bus.rsp_valid), 32'h1);
        check("t3_frozen_result", 32'(bus.rsp_result), 32'hE);
        check("t3_frozen_flags", 32'(bus.rsp_flags), 32'h08);

        bus.rsp_ready = 1'b1;
        nrsp = 0;
        last = 0;
        for (int c = 0; c < 40 && nrsp < 6; c++) begin
            hs      = bus.rsp_valid;
            o_ctl   = bus.rsp_ctl;
            o_res   = bus.rsp_result;
            o_flg   = bus.rsp_flags;
            acc_now = bus.cmd_valid && bus.cmd_ready;
            tick;
            if (acc_now) bus.cmd_valid = 1'b0;
            if (hs) begin
                check("t3_rsp_ctl", 32'(o_ctl), 32'(t_ctl[nrsp]));
                check("t3_rsp_result", 32'(o_res), 32'(t_res[nrsp]));
                check("t3_rsp_flags", 32'(o_flg), 32'(t_flg[nrsp]));
                if (nrsp > 0) check("t3_rsp_gap", 32'(c - last), 32'h2);
                last = c;
                nrsp++;
                check("t3_op_cnt", 32'(op_cnt), 32'(nrsp));
                check("t3_op_cnt2_wrap", 32'(op_cnt2), 32'(cnt2_exp[nrsp-1]));
            end
        end
        check("t3_rsp_count", 32'(nrsp), 32'h6);
        check("t3_op_cnt_final", 32'(op_cnt), 32'h6);
        check("t3_busy_done", 32'(busy), 32'h0);
        check("t3_busy2_done", 32'(busy2), 32'h0);

        // async reset while in ISSUE with three queued
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_cmd(t_ctl[i], t_a[i], t_b[i]);
            check("t4_push_ready", 32'(bus.cmd_ready), 32'h1);
            tick;
        end
        bus.rsp_ready = 1'b1;
        drive_cmd(t_ctl[4], t_a[4], t_b[4]);
        tick;
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        check("t4_issue_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("t4_issue_alu_a", 32'(alu_a), 32'h6);
        check("t4_issue_alu_ctl", 32'(alu_ctl), 32'h1);
        check("t4_issue_cmd_ready", 32'(bus.cmd_ready), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("t4_async");
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick;
            check("t4_quiet_rsp_valid", 32'(bus.rsp_valid), 32'h0);
            check("t4_quiet_busy", 32'(busy), 32'h0);
        end
        drive_cmd(t_ctl[2], t_a[2], t_b[2]);
        tick;
        bus.cmd_valid = 1'b0;
        wait_rsp(ok);
        check("t4_new_rsp_seen", 32'(ok), 32'h1);
        check("t4_new_result", 32'(bus.rsp_result), 32'hF);
        check("t4_new_ctl", 32'(bus.rsp_ctl), 32'h2);
        tick;
        check("t4_new_op_cnt", 32'(op_cnt), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
